// File: rtl/vdp_copper_if.sv
// vdp_copper_if: copper register-write bus toward the VDP host interface.
// The host drives host_write_pending while a CPU write is in flight.
interface vdp_copper_if;
   logic        cop_write_en;
   logic [5:0]  cop_write_address;
   logic [15:0] cop_write_data;
   logic        host_write_pending;

   modport master (
      output cop_write_en,
      output cop_write_address,
      output cop_write_data,
      input  host_write_pending
   );

   modport slave (
      input  cop_write_en,
      input  cop_write_address,
      input  cop_write_data,
      output host_write_pending
   );
endinterface

// File: rtl/vdp_copper.sv
// vdp_copper: raster-synchronised copper issuing VDP register writes.
// Optional VDP_COPPER_HOST_STALL_EN: hold writes while a CPU write is pending.
module vdp_copper #(
   parameter int RAM_ADDR_WIDTH = 11
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      frame_start,
   input  logic [10:0]               raster_x,
   input  logic [9:0]                raster_y,
   output logic [RAM_ADDR_WIDTH-1:0] ram_read_address,
   input  logic [15:0]               ram_read_data,
   output logic                      busy,
   vdp_copper_if.master              wr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WAIT_X,
      S_WAIT_Y,
      S_WR_FETCH,
      S_WR_EMIT,
      S_HALT
   } state_t;

   state_t                    state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [10:0]               tgt_q, tgt_d;
   logic [5:0]                cnt_q, cnt_d;
   logic [5:0]                reg_q, reg_d;
   logic                      inc_q, inc_d;
   logic [5:0]                wa_q, wa_d;
   logic [15:0]               wd_q, wd_d;
   logic                      stall;

`ifdef VDP_COPPER_HOST_STALL_EN
   assign stall = wr.host_write_pending;
`else
   logic unused_pending;
   assign unused_pending = wr.host_write_pending;
   assign stall = 1'b0;
`endif

   // pc always holds the next word to read, so RAM data lines up one cycle on
   assign ram_read_address     = pc_q;
   assign wr.cop_write_address = wa_q;
   assign wr.cop_write_data    = wd_q;
   assign wr.cop_write_en      = (state_q == S_WR_EMIT) && enable && !stall;
   assign busy = (state_q != S_IDLE) && (state_q != S_HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      reg_d   = reg_q;
      inc_d   = inc_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else if (frame_start) begin
         state_d = S_FETCH;
         pc_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_FETCH: begin
               pc_d    = pc_q + 1'b1;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               unique case (ram_read_data[15:14])
                  2'b00: begin
                     tgt_d   = ram_read_data[10:0];
                     state_d = S_WAIT_X;
                  end
                  2'b01: begin
                     tgt_d   = {1'b0, ram_read_data[9:0]};
                     state_d = S_WAIT_Y;
                  end
                  2'b10: begin
                     reg_d   = ram_read_data[5:0];
                     cnt_d   = ram_read_data[11:6];
                     inc_d   = ram_read_data[12];
                     pc_d    = pc_q + 1'b1;
                     state_d = S_WR_FETCH;
                  end
                  default: begin
                     if (ram_read_data[13]) begin
                        state_d = S_HALT;
                     end else begin
                        pc_d    = ram_read_data[RAM_ADDR_WIDTH-1:0];
                        state_d = S_FETCH;
                     end
                  end
               endcase
            end
            S_WAIT_X: begin
               if (raster_x >= tgt_q) state_d = S_FETCH;
            end
            S_WAIT_Y: begin
               if ({1'b0, raster_y} >= tgt_q) state_d = S_FETCH;
            end
            S_WR_FETCH: begin
               wa_d    = reg_q;
               wd_d    = ram_read_data;
               state_d = S_WR_EMIT;
            end
            S_WR_EMIT: begin
               if (!stall) begin
                  if (inc_q) reg_d = reg_q + 6'd1;
                  if (cnt_q == 6'd0) begin
                     state_d = S_FETCH;
                  end else begin
                     cnt_d   = cnt_q - 6'd1;
                     pc_d    = pc_q + 1'b1;
                     state_d = S_WR_FETCH;
                  end
               end
            end
            S_HALT: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         reg_q   <= '0;
         inc_q   <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         reg_q   <= reg_d;
         inc_q   <= inc_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
      end
   end

endmodule

// File: doc/vdp_copper.md
Name: vdp_copper

Overview:
- Raster-synchronised coprocessor that runs a small program from copper RAM.
- Waits on beam position and issues VDP register writes on the cop_write_* bus into the VDP host interface.
- Sits between copper RAM (1-cycle synchronous read) and the host interface; the host interface arbitrates copper writes against CPU writes, CPU winning.

Parameters:
RAM_ADDR_WIDTH, 11, copper RAM word address width; PC and jump targets use this width.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
enable  input  1  copper run enable (VDP control register bit)
frame_start  input  1  one-cycle pulse at raster (0,0)
raster_x  input  11  current beam x
raster_y  input  10  current beam y
ram_read_address  output  RAM_ADDR_WIDTH  copper RAM read address
ram_read_data  input  16  copper RAM data, valid 1 cycle after address
host_write_pending  input  1  CPU write in progress (used only with optional feature)
cop_write_en  output  1  one-cycle register write strobe
cop_write_address  output  6  VDP register address
cop_write_data  output  16  VDP register data
busy  output  1  high when state != IDLE and != HALT

Behaviour:
- Reset values: state IDLE, pc 0, ram_read_address 0, cop_write_en 0, cop_write_address 0, cop_write_data 0, busy 0, word count 0.
- Instruction word [15:14]:
  - 00 WAIT_X: stall until raster_x >= [10:0].
  - 01 WAIT_Y: stall until raster_y >= [9:0].
  - 10 WRITE: [5:0] register, [11:6] N-1 (1..64 data words follow), [12] auto-increment register address after each write, 6-bit wrap.
  - 11 JUMP/HALT: [13]=1 halt until next frame; [13]=0 pc <= [RAM_ADDR_WIDTH-1:0].
- States:
  - IDLE
  - FETCH: drive pc.
  - DECODE: ram_read_data valid, pc+1.
  - WAIT_X / WAIT_Y: compare each cycle; on satisfy go to FETCH the next cycle.
  - WR_FETCH / WR_EMIT: 2 cycles per data word.
  - HALT.
- IDLE -> FETCH on a frame_start pulse while enable=1. pc is loaded with 0.
- Write emission: in WR_EMIT, cop_write_en=1 for exactly one cycle. Address and data are registered and held until the next write. cop_write_en is never high on two consecutive cycles.
- pc increments modulo 2^RAM_ADDR_WIDTH; wrap from max to 0 is legal.
- Latency:
  - frame_start cycle T: first instruction address presented at T+1, decoded at T+2.
  - First write of a WRITE decoded at cycle D: cop_write_en at D+2.
- Wait comparisons use raster_x/raster_y directly, with no extra registering. A wait already satisfied at decode costs exactly 1 cycle in the WAIT state.
- Precedence, highest first:
  1. reset
  2. enable=0: go to IDLE, cop_write_en forced 0 that cycle, no partial write.
  3. frame_start: restart at pc 0 from any state, including mid-WRITE; the remaining words are abandoned.
  4. Normal sequencing.
- HALT: idle until frame_start. JUMP to self is legal and spins at 2 cycles per iteration.
- Reset mid-operation: all outputs return to reset values the next cycle.

Optional Feature:
- Macro: VDP_COPPER_HOST_STALL_EN.
- Defined: in WR_EMIT, if host_write_pending=1, cop_write_en is held 0 and the copper stays in WR_EMIT with address and data unchanged. The write is issued on the first cycle host_write_pending=0, so no write is ever lost to CPU priority.
- Undefined: host_write_pending is ignored, and a conflicting write may be dropped by the host interface.

Test Plan:
- Program at 0: [WRITE reg 0x05 N=1], 0x1234, HALT. Pulse frame_start -> exactly one cop_write_en with addr 0x05, data 0x1234, 4 cycles after the pulse; no further writes until the next frame_start.
- WAIT_Y 100, WRITE reg 0x10 N=3 with auto-increment (0xA,0xB,0xC), HALT -> no write while y<100. At y=100, writes go to 0x10/0x11/0x12 with 0xA/0xB/0xC, one every 2 cycles.
- WAIT_X 300 on the current line with raster_x=299 -> stall. raster_x=300 -> next word fetched the following cycle.
- Long WRITE N=64; pulse frame_start after 10 writes -> writes stop, and pc restarts at 0.
- Deassert enable mid-write -> cop_write_en 0 next cycle and state IDLE.
- JUMP to 2047 with RAM_ADDR_WIDTH=11, containing WRITE reg 1 N=1 -> data read from address 0 after pc wrap.
- With VDP_COPPER_HOST_STALL_EN, hold host_write_pending high for 3 cycles at WR_EMIT -> write issued on cycle 4 with unchanged address and data.
